// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter: VGA scan-out reads have absolute priority, host
// writes are queued in a small FIFO and drained in display-idle cycles.
module fb_arbiter #(
  parameter int HBITS      = 11,
  parameter int VBITS      = 10,
  parameter int HVISIBLE   = 800,
  parameter int VVISIBLE   = 600,
  parameter int AWIDTH     = 19,
  parameter int DWIDTH     = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [HBITS-1:0]              column_addr,
  input  logic [VBITS-1:0]              row_addr,
  output logic [DWIDTH-1:0]             pix_data,
  input  logic                          host_wr_valid,
  output logic                          host_wr_ready,
  input  logic [AWIDTH-1:0]             host_wr_addr,
  input  logic [DWIDTH-1:0]             host_wr_data,
  output logic [AWIDTH-1:0]             mem_addr,
  output logic                          mem_we,
  output logic [DWIDTH-1:0]             mem_wdata,
  input  logic [DWIDTH-1:0]             mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_count
);

  localparam int              PW   = $clog2(FIFO_DEPTH);
  localparam logic [AWIDTH:0] NPIX = (AWIDTH+1)'(HVISIBLE * VVISIBLE);

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data;
  } wr_beat_t;

  wr_beat_t [FIFO_DEPTH-1:0] fifo_q;
  logic [PW-1:0]             rd_ptr, wr_ptr;
  logic [PW:0]               level;
  logic [AWIDTH-1:0]         lin_cnt;
  logic                      disp_active, disp_rd_q, row_blank;
  logic                      full, empty, accept, in_range, push, pop;

  assign disp_active = (int'(column_addr) < HVISIBLE) && (int'(row_addr) < VVISIBLE);
  assign row_blank   = int'(row_addr) >= VVISIBLE;

  assign full          = (level == (PW+1)'(FIFO_DEPTH));
  assign empty         = (level == '0);
  assign host_wr_ready = !full;
  assign in_range      = ({1'b0, host_wr_addr} < NPIX);
  // Out-of-range beats complete the handshake but only bump drop_count.
  assign accept        = host_wr_valid && host_wr_ready && !rst;
  assign push          = accept && in_range;
  assign pop           = !disp_active && !empty && !rst;

  always_ff @(posedge clk) begin
    if (rst || row_blank)  lin_cnt <= '0;
    else if (disp_active)  lin_cnt <= lin_cnt + AWIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) disp_rd_q <= 1'b0;
    else     disp_rd_q <= disp_active;
  end

  // Pointers wrap naturally since FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + (PW+1)'(1);
        2'b01:   level <= level - (PW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{addr: host_wr_addr, data: host_wr_data};
  end

  always_ff @(posedge clk) begin
    if (rst)                                 drop_count <= '0;
    else if (accept && !in_range && drop_count != 8'hFF)
                                             drop_count <= drop_count + 8'd1;
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (!rst) begin
      if (disp_active) begin
        mem_addr = lin_cnt;
      end else if (!empty) begin
        mem_addr  = fifo_q[rd_ptr].addr;
        mem_wdata = fifo_q[rd_ptr].data;
        mem_we    = 1'b1;
      end
    end
  end

  assign pix_data   = disp_rd_q ? mem_rdata : '0;
  assign fifo_level = level;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: RAM model, write scoreboard and pixel
// scoreboard on the default 800x600 instance, plus a tiny-geometry instance
// for a full-frame address sweep.
module tb_fb_arbiter;
  localparam int AW = 19;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  always #5 clk = ~clk;

  logic [10:0]   column_addr = 11'd900;
  logic [9:0]    row_addr    = 10'd700;
  logic [DW-1:0] pix_data;
  logic          host_wr_valid = 1'b0;
  logic          host_wr_ready;
  logic [AW-1:0] host_wr_addr = '0;
  logic [DW-1:0] host_wr_data = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [2:0]    fifo_level;
  logic [7:0]    drop_count;

  fb_arbiter dut (
    .clk(clk), .rst(rst), .column_addr(column_addr), .row_addr(row_addr),
    .pix_data(pix_data), .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fifo_level(fifo_level), .drop_count(drop_count)
  );

  // 8x6 geometry instance for the end-of-frame address and wrap
  logic [3:0]  s_col = 4'd15;
  logic [2:0]  s_row = 3'd7;
  logic [DW-1:0] s_pix, s_wdata;
  logic        s_ready, s_we;
  logic [5:0]  s_addr;
  logic [1:0]  s_lvl;
  logic [7:0]  s_drop;
  logic        s_valid = 1'b0;
  logic [5:0]  s_haddr = '0;
  logic [DW-1:0] s_hdata = '0, s_rdata = '0;

  fb_arbiter #(.HBITS(4), .VBITS(3), .HVISIBLE(8), .VVISIBLE(6), .AWIDTH(6),
               .DWIDTH(24), .FIFO_DEPTH(2)) u_small (
    .clk(clk), .rst(rst), .column_addr(s_col), .row_addr(s_row),
    .pix_data(s_pix), .host_wr_valid(s_valid), .host_wr_ready(s_ready),
    .host_wr_addr(s_haddr), .host_wr_data(s_hdata), .mem_addr(s_addr),
    .mem_we(s_we), .mem_wdata(s_wdata), .mem_rdata(s_rdata),
    .fifo_level(s_lvl), .drop_count(s_drop)
  );

  function automatic logic [DW-1:0] pat(input int i);
    return 24'(i * 37 + 5);
  endfunction

  // Single-port synchronous RAM, one-cycle read latency, preloaded with pat()
  logic [DW-1:0] ram [0:2047];
  bit            wrote [0:2047];
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr[10:0]]   <= mem_wdata;
      wrote[mem_addr[10:0]] <= 1'b1;
    end
    mem_rdata <= wrote[mem_addr[10:0]] ? ram[mem_addr[10:0]] : pat(int'(mem_addr[10:0]));
  end

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } beat_t;
  beat_t         src_q[$];
  beat_t         exp_wr[$];
  logic [DW-1:0] pix_q[$];
  logic [DW-1:0] golden [0:2047];
  int            exp_level = 0;
  int            exp_drop  = 0;
  int            n_assert  = 0;
  int            n_fail    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // One pixel-clock cycle: drive inputs, check at negedge, update models.
  task automatic tick(input int c, input int r, input bit rs);
    bit            vis;
    beat_t         b;
    logic [DW-1:0] pe;
    rst         = rs;
    column_addr = 11'(c);
    row_addr    = 10'(r);
    vis         = (c < 800) && (r < 600);
    if (src_q.size() > 0) begin
      host_wr_valid = 1'b1;
      host_wr_addr  = src_q[0].a;
      host_wr_data  = src_q[0].d;
    end else begin
      host_wr_valid = 1'b0;
      host_wr_addr  = '0;
      host_wr_data  = '0;
    end
    @(negedge clk);
    if (pix_q.size() > 0) chk("pix", pix_data, pix_q.pop_front());
    pe = (vis && !rs && (r * 800 + c) < 2048) ? golden[r * 800 + c] : '0;
    pix_q.push_back(pe);
    chk("level", fifo_level, exp_level);
    chk("drop", drop_count, exp_drop);
    chk("ready", host_wr_ready, exp_level < 4);
    if (rs) begin
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
    end else if (vis) begin
      chk("disp_addr", mem_addr, r * 800 + c);
      chk("disp_we", mem_we, 0);
    end else begin
      chk("drain_we", mem_we, exp_level > 0);
      if (mem_we && exp_wr.size() > 0) begin
        b = exp_wr.pop_front();
        chk("wr_addr", mem_addr, b.a);
        chk("wr_data", mem_wdata, b.d);
        exp_level--;
      end else if (!mem_we) begin
        chk("idle_addr", mem_addr, 0);
      end
    end
    if (host_wr_valid && host_wr_ready && !rs) begin
      b = src_q.pop_front();
      if (b.a < 480000) begin
        exp_wr.push_back(b);
        if (b.a < 2048) golden[b.a] = b.d;
        exp_level++;
      end else if (exp_drop < 255) begin
        exp_drop++;
      end
    end
    if (rs) begin
      exp_level = 0;
      exp_drop  = 0;
      exp_wr.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic scan_row(input int r, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) tick(c, r, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) golden[i] = pat(i);

    // Reset with the host already requesting
    src_q.push_back('{a: 19'd7, d: 24'h111111});
    for (int k = 0; k < 3; k++) begin
      tick(900, 700, 1'b1);
      chk("rst_ready", host_wr_ready, 1);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_pix", pix_data, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_dropcnt", drop_count, 0);
    end
    src_q.delete();
    for (int k = 0; k < 3; k++) tick(900, 700, 1'b0);
    chk("post_rst_level", fifo_level, 0);

    // Full frame on the small geometry: 0..47, then wrap to 0
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 10; c++) begin
        s_col = 4'(c);
        s_row = 3'(r);
        @(negedge clk);
        if (c < 8 && r < 6) chk("small_addr", s_addr, r * 8 + c);
        @(posedge clk);
        #1;
      end
    s_col = 4'd0;
    s_row = 3'd0;
    @(negedge clk);
    chk("small_wrap", s_addr, 0);
    @(posedge clk);
    #1;
    s_col = 4'd15;
    s_row = 3'd7;

    // Display sweep: row 0, part of row 1, vertical blank, back to origin
    tick(0, 600, 1'b0);
    scan_row(0, 0, 899);
    scan_row(1, 0, 10);
    for (int k = 0; k < 4; k++) tick(k, 600, 1'b0);
    tick(0, 0, 1'b0);
    tick(0, 601, 1'b0);

    // Blanking write, then read it back through a scan of pixel (434,1)
    src_q.push_back('{a: 19'd1234, d: 24'hABCDEF});
    tick(850, 10, 1'b0);
    chk("blank_wr_we", mem_we, 1);
    chk("blank_wr_addr", mem_addr, 1234);
    chk("blank_wr_data", mem_wdata, 24'hABCDEF);
    tick(851, 10, 1'b0);
    tick(0, 600, 1'b0);
    scan_row(0, 0, 899);
    scan_row(1, 0, 434);
    chk("scan_1234", pix_data, 24'hABCDEF);
    scan_row(1, 435, 899);
    tick(0, 600, 1'b0);

    // Backpressure across a visible line
    for (int i = 0; i < 10; i++) src_q.push_back('{a: AW'(i), d: 24'h500000 + 24'(i)});
    scan_row(0, 0, 3);
    for (int c = 4; c < 800; c++) begin
      tick(c, 0, 1'b0);
      chk("bp_ready", host_wr_ready, 0);
      chk("bp_level", fifo_level, 4);
    end
    scan_row(0, 800, 899);
    chk("bp_src_done", src_q.size(), 0);
    chk("bp_level_end", fifo_level, 0);
    tick(0, 600, 1'b0);

    // Out-of-range beats
    src_q.push_back('{a: 19'd480000, d: 24'hDEAD00});
    src_q.push_back('{a: 19'd5, d: 24'h55AA55});
    for (int k = 0; k < 5; k++) tick(k, 650, 1'b0);
    chk("oor_drop1", drop_count, 1);
    for (int i = 0; i < 300; i++) src_q.push_back('{a: AW'(480000 + i), d: 24'(i)});
    for (int k = 0; k < 400 && src_q.size() > 0; k++) tick(10, 650, 1'b0);
    chk("oor_src_done", src_q.size(), 0);
    tick(11, 650, 1'b0);
    chk("oor_drop_sat", drop_count, 255);

    // Reset while the FIFO holds three entries
    tick(0, 600, 1'b0);
    for (int i = 0; i < 3; i++) src_q.push_back('{a: AW'(100 + i), d: 24'h0F0F00 + 24'(i)});
    scan_row(0, 0, 2);
    chk("mid_level3", fifo_level, 3);
    tick(3, 0, 1'b1);
    for (int k = 0; k < 20; k++) tick(850 + k, 0, 1'b0);
    chk("mid_level0", fifo_level, 0);
    chk("mid_drop0", drop_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Shares one single-port synchronous framebuffer RAM between the VGA scan-out path and a host write port. It sits between the VGA timing generator and the RAM. It turns the generator's column/row addresses into linear read addresses, returns pixel data in step with the generator's one-cycle-delayed colour inputs, and buffers host writes in a small FIFO. The FIFO drains only in cycles the display does not need the RAM.

## Interface
Parameters:
- HBITS, 11: column address width
- VBITS, 10: row address width
- HVISIBLE, 800: visible pixels per line
- VVISIBLE, 600: visible lines per frame
- AWIDTH, 19: RAM address width; must satisfy 2^AWIDTH ≥ HVISIBLE·VVISIBLE
- DWIDTH, 24: pixel width, {R[23:16], G[15:8], B[7:0]}
- FIFO_DEPTH, 4: host write FIFO entries; power of two, ≥2

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- column_addr  in  HBITS  current column from the timing generator
- row_addr  in  VBITS  current row from the timing generator
- pix_data  out  DWIDTH  pixel for the generator's colour inputs, valid one cycle after its address
- host_wr_valid  in  1  host write request
- host_wr_ready  out  1  FIFO can accept a beat
- host_wr_addr  in  AWIDTH  linear pixel address (row·HVISIBLE + column)
- host_wr_data  in  DWIDTH  pixel value
- mem_addr  out  AWIDTH  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DWIDTH  RAM write data
- mem_rdata  in  DWIDTH  RAM read data, one-cycle latency
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- drop_count  out  8  saturating count of out-of-range host writes

## Operation
- disp_active = (column_addr < HVISIBLE) & (row_addr < VVISIBLE). It is combinational from the inputs.
- Linear display counter lin_cnt[AWIDTH-1:0]:
  - cleared while row_addr ≥ VVISIBLE;
  - otherwise incremented on every disp_active cycle.
  - It is therefore 0 at (0,0), HVISIBLE at (0,1), and so on.
- RAM port mux, strict priority:
  - disp_active: mem_addr = lin_cnt, mem_we = 0. Display always wins.
  - else FIFO not empty: mem_addr/mem_wdata = FIFO head, mem_we = 1, pop the head the same cycle.
  - else: mem_addr = 0, mem_we = 0.
- disp_rd_q <= disp_active each cycle. pix_data = disp_rd_q ? mem_rdata : 0.
- Host handshake:
  - A beat transfers when host_wr_valid & host_wr_ready.
  - host_wr_ready = !full. It is registered-state based and never depends on host_wr_valid.
  - Push and pop in the same cycle leaves the level unchanged. This is legal whenever the FIFO is not full.
- Beats with host_wr_addr ≥ HVISIBLE·VVISIBLE:
  - are still accepted (ready is unaffected);
  - are not pushed into the FIFO;
  - increment drop_count, which saturates at 255.
- FIFO order is preserved. Writes are never reordered or merged.

## Timing
- Reset values: host_wr_ready = 1, mem_we = 0, mem_addr = 0, pix_data = 0, fifo_level = 0, drop_count = 0, lin_cnt = 0, disp_rd_q = 0, FIFO emptied.
- Reset mid-operation discards all pending FIFO entries. Those writes are lost by design.
- Display read path: address in cycle t, pix_data valid in cycle t+1. This matches the generator's delayed colour mux.
- Host write latency: a beat accepted in cycle t reaches mem_we at the earliest in cycle t+1. This holds only if cycle t+1 is not disp_active.
- During a visible line the FIFO fills. With FIFO_DEPTH full, ready stays low until the first blanking cycle pops an entry. Ready returns high in the cycle after that pop.
- Drain rate: one write per non-active cycle.
- fifo_level updates the cycle after a push or pop.

## Test plan
- Reset check: assert rst for 3 cycles with host_wr_valid=1. Required: all outputs at their reset values, and no beat accepted while rst=1.
- Display sequencing: drive a counter sweep of the default 800×600 timing. Required:
  - mem_addr = 0, 1, …, 799 on row 0 and 800 on (0,1);
  - mem_addr = 479999 at (799,599), then lin_cnt resets during vertical blanking;
  - pix_data equals the RAM model content one cycle later and is 0 in blanking.
- Blanking write: during column 850 of row 10, push addr 1234, data 0xABCDEF. Required: mem_we=1 with mem_addr=1234 and mem_wdata=0xABCDEF on the next cycle. A later scan of pixel (434,1) returns 0xABCDEF.
- Backpressure: starting at column 0 of a visible row, hold host_wr_valid high with addresses 0..9. Required:
  - 4 beats accepted, then ready=0 and fifo_level=4 until column 800;
  - writes to 0,1,2,3 issue in order on columns 800–803;
  - the remaining beats follow without loss.
- Out-of-range: push addr 480000, then addr 5. Required: drop_count=1 and only addr 5 written. After 300 out-of-range beats, drop_count=255.
- Reset mid-operation: fill the FIFO with 3 entries during a visible line, then pulse rst. Required: fifo_level=0, and no mem_we in the following blanking.
